// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller: FSM state encoding,
// default LFSR polynomial/seed and result-field widths/constants.
package adder_bist_pkg;

  localparam int unsigned FAIL_CNT_W = 8;
  localparam int unsigned FAIL_IDX_W = 16;
  localparam logic [FAIL_IDX_W-1:0] FAIL_IDX_NONE = 16'hFFFF;

  // Default LFSR over 33 bits (2*16+1): x^33 + x^20 + 1
  localparam logic [32:0] DEF_POLY = 33'h1_0008_0000;
  localparam logic [32:0] DEF_SEED = 33'h0_1234_5678;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_CHECK_LAST,
    ST_DONE
  } bist_state_e;

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Adder-core bus between the BIST controller (master) and the adder (slave).
//   add_a, add_b, add_cin, add_sel : operand drive, master -> adder
//   add_sum, add_co                : adder result,  adder -> master
interface adder_bist_ctrl_if #(
  parameter int unsigned N = 16
);

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic         add_sel;
  logic [N-1:0] add_sum;
  logic         add_co;

  modport master (
    output add_a, add_b, add_cin, add_sel,
    input  add_sum, add_co
  );

  modport slave (
    input  add_a, add_b, add_cin, add_sel,
    output add_sum, add_co
  );

endinterface

// File: rtl/bist_lfsr.sv
// Right-shifting Galois LFSR pattern source.
//   clk, rst : clock, async active-high reset (reset value = SEED)
//   load     : reload SEED (priority over step)
//   step     : advance one LFSR step
//   value    : current LFSR state
module bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter int unsigned   W    = 33,
  parameter logic [W-1:0]  POLY = W'(DEF_POLY),
  parameter logic [W-1:0]  SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] value
);

  // Shifted-out LSB folds back through the polynomial taps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ POLY) : (value >> 1);
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for the N-bit adder core. Passes functional pin operands
// through in IDLE; on pin_start applies NUM_PAT LFSR patterns, checks each
// adder result against an internal golden sum and reports the outcome.
//   pin_clk, pin_rst           : clock, async active-high reset
//   pin_start                  : run request, honoured only in IDLE
//   pin_a/b/cin/sel_func       : functional operands
//   adder                      : adder-core bus (master side)
//   pin_busy, pin_done         : run in progress / one-cycle completion pulse
//   pin_pass, pin_fail_cnt,
//   pin_fail_idx               : last-run result, count, first failing index
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned       N       = 16,
  parameter int unsigned       NUM_PAT = 256,
  parameter logic [2*N:0]      POLY    = (2*N+1)'(DEF_POLY),
  parameter logic [2*N:0]      SEED    = (2*N+1)'(DEF_SEED)
) (
  input  logic                  pin_clk,
  input  logic                  pin_rst,
  input  logic                  pin_start,
  input  logic [N-1:0]          pin_a_func,
  input  logic [N-1:0]          pin_b_func,
  input  logic                  pin_cin_func,
  input  logic                  pin_sel_func,
  adder_bist_ctrl_if.master     adder,
  output logic                  pin_busy,
  output logic                  pin_done,
  output logic                  pin_pass,
  output logic [FAIL_CNT_W-1:0] pin_fail_cnt,
  output logic [FAIL_IDX_W-1:0] pin_fail_idx
);

  localparam int unsigned LW    = 2 * N + 1;
  localparam int unsigned CNT_W = FAIL_IDX_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAT - 1);

  // Pattern index must fit the 16-bit fail index without hitting the NONE code
  if (NUM_PAT < 2 || NUM_PAT > 65535) begin : g_bad_num_pat
    $error("adder_bist_ctrl: NUM_PAT must be in 2..65535");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("adder_bist_ctrl: SEED must be non-zero");
  end

  bist_state_e state_q, state_d;

  logic [LW-1:0]    lfsr_val;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] drv_idx_q;
  logic [N-1:0]     drv_a_q, drv_b_q;
  logic             drv_cin_q;
  logic [N:0]       golden_q, golden_d;

  logic lfsr_load, issue, cmp_en, busy_d, done_d;
  logic mismatch, fail_hit;

  bist_lfsr #(
    .W    (LW),
    .POLY (POLY),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (pin_clk),
    .rst   (pin_rst),
    .load  (lfsr_load),
    .step  (issue),
    .value (lfsr_val)
  );

  // State register
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (pin_start) state_d = ST_INIT;
      ST_INIT:       state_d = ST_RUN;
      ST_RUN:        if (cnt_q == LAST_IDX) state_d = ST_CHECK_LAST;
      ST_CHECK_LAST: state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Control decode; busy/done are registered from the next state
  always_comb begin
    lfsr_load = 1'b0;
    issue     = 1'b0;
    cmp_en    = 1'b0;
    case (state_q)
      ST_INIT:       lfsr_load = 1'b1;
      ST_RUN: begin
        issue  = 1'b1;
        // First RUN cycle has no pattern on the adder yet
        cmp_en = (cnt_q != '0);
      end
      ST_CHECK_LAST: cmp_en = 1'b1;
      default: ;
    endcase
    busy_d = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_CHECK_LAST);
    done_d = (state_d == ST_DONE);
  end

  assign golden_d = {1'b0, lfsr_val[N-1:0]} + {1'b0, lfsr_val[2*N-1:N]}
                  + (N+1)'(lfsr_val[2*N]);
  assign mismatch = ({adder.add_co, adder.add_sum} != golden_q);
  assign fail_hit = cmp_en && mismatch;

  // Pattern issue, compare and result bookkeeping
  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      cnt_q        <= '0;
      drv_idx_q    <= '0;
      drv_a_q      <= '0;
      drv_b_q      <= '0;
      drv_cin_q    <= 1'b0;
      golden_q     <= '0;
      pin_busy     <= 1'b0;
      pin_done     <= 1'b0;
      pin_pass     <= 1'b0;
      pin_fail_cnt <= '0;
      pin_fail_idx <= FAIL_IDX_NONE;
    end else begin
      pin_busy <= busy_d;
      pin_done <= done_d;

      if (lfsr_load) begin
        cnt_q        <= '0;
        pin_pass     <= 1'b0;
        pin_fail_cnt <= '0;
        pin_fail_idx <= FAIL_IDX_NONE;
      end

      if (issue) begin
        drv_a_q   <= lfsr_val[N-1:0];
        drv_b_q   <= lfsr_val[2*N-1:N];
        drv_cin_q <= lfsr_val[2*N];
        golden_q  <= golden_d;
        drv_idx_q <= cnt_q;
        cnt_q     <= (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      end

      if (fail_hit) begin
        if (pin_fail_cnt != '1) pin_fail_cnt <= pin_fail_cnt + FAIL_CNT_W'(1);
        if (pin_fail_idx == FAIL_IDX_NONE) pin_fail_idx <= drv_idx_q;
      end

      // Final compare happens on the same edge that enters DONE
      if (done_d) pin_pass <= (pin_fail_cnt == '0) && !fail_hit;
    end
  end

  // Operand mux: registered pattern while busy, functional pins otherwise
  assign adder.add_a   = pin_busy ? drv_a_q   : pin_a_func;
  assign adder.add_b   = pin_busy ? drv_b_q   : pin_b_func;
  assign adder.add_cin = pin_busy ? drv_cin_q : pin_cin_func;
  assign adder.add_sel = pin_busy ? 1'b1      : pin_sel_func;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Self-checking bench for adder_bist_ctrl with a behavioural adder model
// that can inject faults, and a pattern/result reference model.
module tb_adder_bist_ctrl;

  localparam int unsigned N       = 16;
  localparam int unsigned NUM_PAT = 256;
  localparam logic [32:0] POLY    = 33'h1_0008_0000;
  localparam logic [32:0] SEED    = 33'h0_1234_5678;

  logic        clk, rst, start;
  logic [15:0] a_func, b_func;
  logic        cin_func, sel_func;
  logic        busy, done, pass;
  logic [7:0]  fail_cnt;
  logic [15:0] fail_idx;

  int total = 0;
  int bad   = 0;

  adder_bist_ctrl_if #(.N(N)) bus ();

  adder_bist_ctrl #(
    .N       (N),
    .NUM_PAT (NUM_PAT)
  ) dut (
    .pin_clk      (clk),
    .pin_rst      (rst),
    .pin_start    (start),
    .pin_a_func   (a_func),
    .pin_b_func   (b_func),
    .pin_cin_func (cin_func),
    .pin_sel_func (sel_func),
    .adder        (bus),
    .pin_busy     (busy),
    .pin_done     (done),
    .pin_pass     (pass),
    .pin_fail_cnt (fail_cnt),
    .pin_fail_idx (fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault modes: 0 clean, 1 result bit stuck, 2 carry inverted on pattern 5, 3 carry always inverted
  int          fault_mode = 0;
  int          fault_bit  = 0;
  logic        fault_val  = 1'b0;
  logic [32:0] pat5_vec   = '0;

  always_comb begin
    logic [16:0] r;
    r = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);
    case (fault_mode)
      1: r[fault_bit] = fault_val;
      2: if ({bus.add_cin, bus.add_b, bus.add_a} == pat5_vec) r[16] = ~r[16];
      3: r[16] = ~r[16];
      default: ;
    endcase
    bus.add_sum = r[15:0];
    bus.add_co  = r[16];
  end

  // Reference: the pattern list and the true sums
  logic [32:0] pats [NUM_PAT];
  logic [16:0] gold [NUM_PAT];

  function automatic void gen_patterns();
    logic [32:0] v;
    v = SEED;
    for (int i = 0; i < NUM_PAT; i++) begin
      pats[i] = v;
      gold[i] = 17'(v[15:0]) + 17'(v[31:16]) + 17'(v[32]);
      v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    end
  endfunction

  function automatic void ref_result(input int mode, input int fb, input logic fv,
                                     output int cnt, output int idx);
    cnt = 0;
    idx = 'hFFFF;
    for (int i = 0; i < NUM_PAT; i++) begin
      logic [16:0] f;
      f = gold[i];
      case (mode)
        1: f[fb] = fv;
        2: if (i == 5) f[16] = ~f[16];
        3: f[16] = ~f[16];
        default: ;
      endcase
      if (f != gold[i]) begin
        if (cnt < 255) cnt++;
        if (idx == 'hFFFF) idx = i;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_func();
    a_func   = 16'($urandom);
    b_func   = 16'($urandom);
    cin_func = 1'($urandom);
    sel_func = 1'($urandom);
  endtask

  // One BIST run; cycle k is sampled on the negedge after the k-th edge from the start edge
  task automatic run_bist(input int rst_at, input bit poke, input bit chk_drive,
                          input int exp_cnt, input int exp_idx);
    int busy_n = 0;
    int done_n = 0;
    int done_k = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < NUM_PAT + 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_fail_idx", fail_idx, 16'hFFFF);
        chk("rst_pass_a", bus.add_a, a_func);
        chk("rst_pass_sel", bus.add_sel, sel_func);
        @(negedge clk); rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          if (done) done_n++;
        end
        chk("rst_no_done", done_n, 0);
        chk("rst_idle_busy", busy, 0);
        return;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (chk_drive && k >= 2 && k <= NUM_PAT + 1) begin
        chk($sformatf("drive_pat%0d", k - 2), {bus.add_cin, bus.add_b, bus.add_a}, pats[k-2]);
        chk("drive_sel", bus.add_sel, 1);
      end
      start = poke && (k == 50);
      rand_func();
    end
    chk("busy_cycles", busy_n, NUM_PAT + 2);
    chk("done_pulses", done_n, 1);
    chk("done_cycle", done_k + 1, NUM_PAT + 3);
    chk("pass", pass, (exp_cnt == 0));
    chk("fail_cnt", fail_cnt, exp_cnt);
    chk("fail_idx", fail_idx, exp_idx);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sel;
    logic [15:0] ea, eb;
    logic        ecin, esel;
  } fvec_t;

  fvec_t ftab [6];

  initial begin
    int ec, ei;
    gen_patterns();
    pat5_vec = pats[5];
    rst = 1'b1; start = 1'b0;
    a_func = '0; b_func = '0; cin_func = 1'b0; sel_func = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fail_cnt", fail_cnt, 0);
    chk("reset_fail_idx", fail_idx, 16'hFFFF);

    // Functional passthrough vectors
    ftab[0] = '{16'h000F, 16'h0000, 1'b0, 1'b1, 16'h000F, 16'h0000, 1'b0, 1'b1};
    ftab[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    ftab[2] = '{16'hAAAA, 16'h5555, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1};
    ftab[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    for (int i = 4; i < 6; i++) begin
      ftab[i].a = 16'($urandom); ftab[i].b = 16'($urandom);
      ftab[i].cin = 1'($urandom); ftab[i].sel = 1'($urandom);
      ftab[i].ea = ftab[i].a; ftab[i].eb = ftab[i].b;
      ftab[i].ecin = ftab[i].cin; ftab[i].esel = ftab[i].sel;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_func = ftab[i].a; b_func = ftab[i].b;
      cin_func = ftab[i].cin; sel_func = ftab[i].sel;
      #1;
      chk($sformatf("func%0d_a", i), bus.add_a, ftab[i].ea);
      chk($sformatf("func%0d_b", i), bus.add_b, ftab[i].eb);
      chk($sformatf("func%0d_cin", i), bus.add_cin, ftab[i].ecin);
      chk($sformatf("func%0d_sel", i), bus.add_sel, ftab[i].esel);
      chk($sformatf("func%0d_busy", i), busy, 0);
      chk($sformatf("func%0d_idx", i), fail_idx, 16'hFFFF);
    end

    // Clean run with pattern-drive checks and a start pulse mid-run
    fault_mode = 0;
    ref_result(0, 0, 1'b0, ec, ei);
    run_bist(-1, 1'b1, 1'b1, ec, ei);

    // Sum bit 7 stuck-at-0
    fault_mode = 1; fault_bit = 7; fault_val = 1'b0;
    ref_result(1, 7, 1'b0, ec, ei);
    run_bist(-1, 1'b0, 1'b0, ec, ei);

    // Carry inverted on pattern 5 only
    fault_mode = 2;
    ref_result(2, 0, 1'b0, ec, ei);
    run_bist(-1, 1'b0, 1'b0, ec, ei);

    // Every pattern fails: count saturates
    fault_mode = 3;
    ref_result(3, 0, 1'b0, ec, ei);
    run_bist(-1, 1'b0, 1'b0, ec, ei);

    // Reset at RUN cycle 100, then a full clean run
    fault_mode = 0;
    run_bist(100, 1'b0, 1'b0, 0, 'hFFFF);
    ref_result(0, 0, 1'b0, ec, ei);
    run_bist(-1, 1'b0, 1'b0, ec, ei);

    // Random stuck-at faults on any result bit
    for (int r = 0; r < 3; r++) begin
      fault_mode = 1;
      fault_bit  = int'($urandom_range(0, 16));
      fault_val  = 1'($urandom);
      ref_result(1, fault_bit, fault_val, ec, ei);
      run_bist(-1, 1'b0, 1'b0, ec, ei);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
